// File: rtl/par_serial8.sv
// Byte-to-bit serializer: a 2-entry byte FIFO feeds an MSB-first shift register,
// and the idle character goes out whenever no byte is queued at a load point.
module par_serial8 #(
    parameter logic [7:0]  IDLE_CHAR = 8'hBC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data8,
    input  logic       in8,
    output logic       ready8,
    output logic       out_serial,
    output logic       out_valid,
    output logic       byte_start,
    output logic       err_ovf
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [7:0] shreg_q,    shreg_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic       cur_data_q, cur_data_d;
    logic [7:0] fifo_q [2];
    logic [7:0] fifo_d [2];
    logic       rd_ptr_q,   rd_ptr_d;
    logic       wr_ptr_q,   wr_ptr_d;
    logic [1:0] count_q,    count_d;
    logic       err_q,      err_d;

    logic push, drop, load, pop;

    // ready8 comes from the registered count only, so upstream sees no input-to-output path
    assign ready8     = (count_q < FULL);
    assign out_serial = shreg_q[7];
    assign byte_start = (bit_cnt_q == 3'd0);
    assign out_valid  = cur_data_q;
    assign err_ovf    = err_q;

    always_comb begin
        push = in8 && ready8;
        drop = in8 && !ready8;
        load = (bit_cnt_q == 3'd7);
        pop  = load && (count_q != 2'd0);

        bit_cnt_d  = bit_cnt_q + 3'd1;
        shreg_d    = {shreg_q[6:0], 1'b0};
        cur_data_d = cur_data_q;

        // A byte pushed on this same edge is not visible yet: load uses the pre-edge count
        if (load) begin
            if (count_q != 2'd0) begin
                shreg_d    = fifo_q[rd_ptr_q];
                cur_data_d = 1'b1;
            end else begin
                shreg_d    = IDLE_CHAR;
                cur_data_d = 1'b0;
            end
        end

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = in_data8;
        end

        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        err_d = err_q | drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q    <= IDLE_CHAR;
            bit_cnt_q  <= '0;
            cur_data_q <= 1'b0;
            fifo_q     <= '{default: '0};
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            cur_data_q <= cur_data_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_par_serial8.sv
// Directed bench for par_serial8: idle pattern, latency, load-edge eligibility,
// overflow, mid-character reset and sustained line-rate streaming.
module tb_par_serial8;

    logic       clk;
    logic       reset;
    logic [7:0] in_data8;
    logic       in8;
    logic       ready8;
    logic       out_serial;
    logic       out_valid;
    logic       byte_start;
    logic       err_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int ph      = 0;   // expected bit position since reset release

    par_serial8 #(.IDLE_CHAR(8'hBC), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data8   (in_data8),
        .in8        (in8),
        .ready8     (ready8),
        .out_serial (out_serial),
        .out_valid  (out_valid),
        .byte_start (byte_start),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 8;
    endtask

    task automatic goto_phase(input int p);
        while (ph != p) tick();
    endtask

    // Samples one 8-bit character slot (MSB first), advancing 8 clocks.
    task automatic capture_char(output logic [7:0] bits, output logic [7:0] vld,
                                output logic [7:0] bs);
        for (int i = 0; i < 8; i++) begin
            bits[7-i] = out_serial;
            vld[7-i]  = out_valid;
            bs[7-i]   = byte_start;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [7:0] b, v, s;
        reset = 1'b1;
        in8 = 1'b0;
        in_data8 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        ph = 0;
        n_tests++;
        if (ready8 !== 1'b1 || err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready8=%b err_ovf=%b, required 1 0", ready8, err_ovf);
        end
        for (int c = 0; c < 3; c++) begin
            capture_char(b, v, s);
            n_tests++;
            if (b !== 8'hBC || v !== 8'h00 || s !== 8'h80) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: bits=%h valid=%h start=%h, required bc 00 80", c, b, v, s);
            end
        end
        n_tests++;
        if (ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: ready8=%b, required 1", ready8);
        end
    endtask

    task automatic test_single();
        logic [7:0] b, v, s;
        goto_phase(3);
        in8 = 1'b1;
        in_data8 = 8'hA5;
        tick();
        in8 = 1'b0;
        n_tests++;
        if (ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: ready8=%b, required 1", ready8);
        end
        goto_phase(0);
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'hA5 || v !== 8'hFF || s !== 8'h80) begin
            n_fail++;
            $display("FAIL single_data: bits=%h valid=%h start=%h, required a5 ff 80", b, v, s);
        end
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'hBC || v !== 8'h00) begin
            n_fail++;
            $display("FAIL single_after: bits=%h valid=%h, required bc 00", b, v);
        end
    endtask

    task automatic test_load_edge();
        logic [7:0] b, v, s;
        goto_phase(7);
        in8 = 1'b1;
        in_data8 = 8'h3C;
        tick();
        in8 = 1'b0;
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'hBC || v !== 8'h00) begin
            n_fail++;
            $display("FAIL load_edge_slot: bits=%h valid=%h, required bc 00", b, v);
        end
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'h3C || v !== 8'hFF || s !== 8'h80) begin
            n_fail++;
            $display("FAIL load_edge_next: bits=%h valid=%h start=%h, required 3c ff 80", b, v, s);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b, v, s;
        goto_phase(0);
        in8 = 1'b1;
        in_data8 = 8'h11;
        tick();
        n_tests++;
        if (ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_ready1: ready8=%b, required 1", ready8);
        end
        in_data8 = 8'h22;
        tick();
        n_tests++;
        if (ready8 !== 1'b0 || err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: ready8=%b err_ovf=%b, required 0 0", ready8, err_ovf);
        end
        in_data8 = 8'h33;
        tick();
        in8 = 1'b0;
        n_tests++;
        if (err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: err_ovf=%b, required 1", err_ovf);
        end
        goto_phase(0);
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'h11 || v !== 8'hFF) begin
            n_fail++;
            $display("FAIL ovf_first: bits=%h valid=%h, required 11 ff", b, v);
        end
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'h22 || v !== 8'hFF) begin
            n_fail++;
            $display("FAIL ovf_second: bits=%h valid=%h, required 22 ff", b, v);
        end
        capture_char(b, v, s);
        n_tests++;
        if (b !== 8'hBC || v !== 8'h00 || err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_tail: bits=%h valid=%h err_ovf=%b, required bc 00 1", b, v, err_ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b, v, s;
        goto_phase(0);
        in8 = 1'b1;
        in_data8 = 8'hFF;
        tick();
        in_data8 = 8'h00;
        tick();
        in8 = 1'b0;
        goto_phase(0);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_loaded: out_valid=%b, required 1", out_valid);
        end
        repeat (4) tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || byte_start !== 1'b1 || out_serial !== 1'b1 ||
            err_ovf !== 1'b0 || ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b start=%b serial=%b err=%b ready=%b, required 0 1 1 0 1",
                     out_valid, byte_start, out_serial, err_ovf, ready8);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        ph = 0;
        for (int c = 0; c < 3; c++) begin
            capture_char(b, v, s);
            n_tests++;
            if (b !== 8'hBC || v !== 8'h00 || s !== 8'h80) begin
                n_fail++;
                $display("FAIL mid_after[%0d]: bits=%h valid=%h start=%h, required bc 00 80", c, b, v, s);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b, v, s;
        goto_phase(0);
        for (int slot = 0; slot < 10; slot++) begin
            for (int i = 0; i < 8; i++) begin
                b[7-i] = out_serial;
                v[7-i] = out_valid;
                s[7-i] = byte_start;
                in8 = (i == 0 && slot < 8);
                in_data8 = 8'(slot + 1);
                tick();
            end
            in8 = 1'b0;
            if (slot == 0 || slot == 9) begin
                n_tests++;
                if (b !== 8'hBC || v !== 8'h00) begin
                    n_fail++;
                    $display("FAIL stream_idle[%0d]: bits=%h valid=%h, required bc 00", slot, b, v);
                end
            end else begin
                n_tests++;
                if (b !== 8'(slot) || v !== 8'hFF || s !== 8'h80) begin
                    n_fail++;
                    $display("FAIL stream_byte[%0d]: bits=%h valid=%h start=%h, required %h ff 80",
                             slot, b, v, s, 8'(slot));
                end
            end
        end
        n_tests++;
        if (err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_err: err_ovf=%b, required 0", err_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_load_edge();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/par_serial8.md
Name: par_serial8

Overview:
- Serializer stage directly downstream of the 32->8 converter.
- Consumes the byte stream (data plus valid strobe) and shifts each byte out MSB-first, one bit per clk.
- Sends the idle character whenever no data byte is queued.
- A 2-entry byte buffer absorbs timing mismatch with the upstream stage.
- Overflow (byte offered while the buffer is full) is flagged with a sticky error bit.

Parameters:
- IDLE_CHAR, 8'hBC, character serialized when the buffer is empty at a load point.
- BUF_DEPTH, 2, byte buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  bit clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data8  input  8  byte from the upstream converter.
- in8  input  1  in_data8 valid strobe.
- ready8  output  1  buffer can accept a byte this cycle.
- out_serial  output  1  serialized bit.
- out_valid  output  1  current character is a data byte (0 while IDLE_CHAR is on the line).
- byte_start  output  1  high during the first (MSB) bit of every character.
- err_ovf  output  1  sticky overflow flag.

Behaviour:
- Registered state:
  - shreg[7:0]: shift register.
  - bit_cnt[2:0]: bit counter.
  - cur_data: current-character-is-data flag.
  - buf[0..1], rd_ptr, wr_ptr, count[1:0]: byte buffer.
  - err_ovf.
- Reset (asynchronous, takes effect immediately, including mid-character; a partial character is not resumed):
  - shreg=IDLE_CHAR, bit_cnt=0, cur_data=0, count=0, rd_ptr=wr_ptr=0, err_ovf=0.
  - Resulting outputs: out_serial=IDLE_CHAR[7] (1 for 8'hBC), out_valid=0, byte_start=1, ready8=1, err_ovf=0.
  - Buffer contents are discarded.
- Outputs are driven from registers only; no input-to-output combinational path except ready8 = (count < 2), which depends only on registered count.
  - out_serial = shreg[7]
  - byte_start = (bit_cnt == 0)
  - out_valid = cur_data
- Each clk edge, bit_cnt increments and wraps 7->0.
  - bit_cnt != 7: shreg <= {shreg[6:0],1'b0}.
  - bit_cnt == 7 (load edge), using pre-edge count:
    - count > 0: shreg <= buf[rd_ptr], cur_data <= 1, pop (rd_ptr toggles).
    - count == 0: shreg <= IDLE_CHAR, cur_data <= 0.
- Push: in8 && ready8 writes buf[wr_ptr] and toggles wr_ptr.
  - in8 with ready8==0 drops the byte and sets err_ovf <= 1. err_ovf is cleared only by reset.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - At count==2 no push is possible, even on a pop edge; ready8 is evaluated from pre-edge count.
- Eligibility: a byte pushed on a load edge is not eligible for that load. Minimum latency is from the push edge to the next load edge, with the MSB on out_serial immediately after that load edge.
- Throughput: one byte per 8 clk. Sustained input above this rate overflows after 2 buffered bytes.
- Line order is strictly FIFO. Data characters are never split, repeated or reordered.

Test Plan:
- Reset, no input for 24 clk -> out_serial repeats 1,0,1,1,1,1,0,0 three times; out_valid=0; byte_start high every 8th clk starting at reset release; ready8=1.
- Single push 8'hA5 at bit_cnt=3 -> after next load edge out_serial=1,0,1,0,0,1,0,1 with out_valid=1 for those 8 bits, then returns to 8'hBC pattern with out_valid=0.
- Push 8'h3C exactly on a load edge -> that slot is IDLE_CHAR; 8'h3C is sent in the following slot.
- Push 8'h11, 8'h22, 8'h33 on three consecutive clk while 8'hBC is shifting:
  - ready8 drops after the second push.
  - 8'h33 is dropped and err_ovf=1, held.
  - Line carries 8'h11 then 8'h22 back-to-back with out_valid continuously 1, then idle.
- Push 8'hFF and 8'h00, then assert reset at bit 4 of 8'hFF -> immediately out_valid=0, byte_start=1, out_serial=1, err_ovf=0, ready8=1; after release only 8'hBC characters, no 8'h00.
- Push one byte every 8 clk for 64 clk (8'h01..8'h08) -> all 8 bytes sent in order, contiguous with out_valid=1, err_ovf stays 0.
